// File: rtl/shared_resource_unit.sv
// Shared multi-cycle resource between pipeline stage 3 and stage 4.
// Requests are queued in a small FIFO, each one is run through a fixed-latency
// add-constant operation, and results are handed to stage 4 with valid/stall.
module shared_resource_unit #(
    parameter int unsigned             DATA_WIDTH = 32,
    parameter int unsigned             DEPTH      = 4,
    parameter int unsigned             LATENCY    = 3,
    parameter logic [DATA_WIDTH-1:0]   ADD_CONST  = 32'h1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    input  logic                  in_flush,
    output logic                  out_stall,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    output logic                  out_flush,
    input  logic                  in_stall,
    output logic [15:0]           ops_done
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] Full    = CW'(DEPTH);
    localparam logic [3:0]    CntInit = 4'(LATENCY - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] operand_q, operand_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_flush_q;
    logic [15:0]           ops_done_q, ops_done_d;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  push;
    logic                  pop;

    // Stall depends only on the registered occupancy.
    assign out_stall = (count_q == Full);
    assign push      = in_valid && !out_stall && !in_flush;

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign out_flush = out_flush_q;
    assign ops_done  = ops_done_q;

    // FSM next state: fetch from FIFO, count down latency, hold result until taken.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        operand_d   = operand_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        ops_done_d  = ops_done_q;
        pop         = 1'b0;
        if (in_flush) begin
            // Flush wins over every transition and drops any pending result.
            state_d     = StIdle;
            out_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (count_q != '0) begin
                        pop       = 1'b1;
                        operand_d = mem[rd_ptr_q];
                        cnt_d     = CntInit;
                        state_d   = StBusy;
                    end
                end
                StBusy: begin
                    if (cnt_q != 4'd0) begin
                        cnt_d = cnt_q - 4'd1;
                    end else begin
                        out_data_d  = operand_q + ADD_CONST;
                        out_valid_d = 1'b1;
                        state_d     = StDone;
                    end
                end
                StDone: begin
                    if (!in_stall) begin
                        ops_done_d  = ops_done_q + 16'd1;
                        out_valid_d = 1'b0;
                        if (count_q != '0) begin
                            pop       = 1'b1;
                            operand_d = mem[rd_ptr_q];
                            cnt_d     = CntInit;
                            state_d   = StBusy;
                        end else begin
                            state_d = StIdle;
                        end
                    end
                end
                default: begin
                    state_d     = StIdle;
                    out_valid_d = 1'b0;
                end
            endcase
        end
    end

    // FIFO pointer and occupancy next state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (in_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
        end
    end

    // FIFO storage; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= in_data;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            operand_q   <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_flush_q <= 1'b0;
            ops_done_q  <= 16'd0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            operand_q   <= operand_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_flush_q <= in_flush;
            ops_done_q  <= ops_done_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

endmodule

// File: tb/tb_shared_resource_unit.sv
// Self-checking bench for shared_resource_unit: scoreboard of expected results
// pushed on accept and popped on transfer, plus directed timing checks.
module tb_shared_resource_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_flush;
    logic        out_stall;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_flush;
    logic        in_stall;
    logic [15:0] ops_done;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] sb [$];
    logic [15:0] exp_ops  = 16'd0;
    bit          rst_seen = 1'b0;
    bit          gap_chk  = 1'b0;
    int          cyc      = 0;
    int          last_xfer = -1;

    shared_resource_unit dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_flush  (in_flush),
        .out_stall (out_stall),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_flush (out_flush),
        .in_stall  (in_stall),
        .ops_done  (ops_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor at the falling edge: everything is stable until the next rising edge,
    // so the handshakes that edge will perform are known here.
    always @(negedge clk) begin
        logic [31:0] e;
        if (rst_seen && reset === 1'b1) check("ops_done", {16'd0, ops_done}, {16'd0, exp_ops});
        if (reset !== 1'b1) begin
            sb.delete();
            exp_ops  = 16'd0;
            rst_seen = 1'b1;
        end else if (rst_seen) begin
            if (in_flush === 1'b1) begin
                sb.delete();
            end else begin
                if (out_valid === 1'b1 && in_stall === 1'b0) begin
                    if (sb.size() == 0) begin
                        check("sb_size", 32'(sb.size()), 32'd1);
                    end else begin
                        e = sb.pop_front();
                        check("result", out_data, e);
                    end
                    exp_ops = exp_ops + 16'd1;
                    if (gap_chk && last_xfer >= 0) check("gap", 32'(cyc - last_xfer), 32'd4);
                    last_xfer = cyc;
                end
                if (in_valid === 1'b1 && out_stall === 1'b0) sb.push_back(in_data + 32'h1);
            end
        end
        if (!gap_chk) last_xfer = -1;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    task automatic send(input logic [31:0] d);
        in_data  = d;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int g = 0;
        while ((sb.size() != 0 || out_valid) && g < 300) begin
            tick();
            g++;
        end
        check(tag, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        logic [31:0] d0;
        logic [15:0] ops0;
        int          g;
        reset = 1'b0; in_data = '0; in_valid = 1'b0; in_flush = 1'b0; in_stall = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_data",  out_data, 32'd0);
        check("rst_ops",   {16'd0, ops_done}, 32'd0);
        check("rst_stall", {31'd0, out_stall}, 32'd0);
        check("rst_flush", {31'd0, out_flush}, 32'd0);

        // Single request: valid appears after the 4th edge past acceptance.
        send(32'h10);
        repeat (3) tick();
        check("t1_not_yet", {31'd0, out_valid}, 32'd0);
        tick();
        check("t1_valid", {31'd0, out_valid}, 32'd1);
        check("t1_data",  out_data, 32'h11);
        tick();
        check("t1_one_cycle", {31'd0, out_valid}, 32'd0);
        check("t1_ops", {16'd0, ops_done}, 32'd1);

        // Wrap of the add.
        send(32'hFFFF_FFFF);
        repeat (4) tick();
        check("t2_valid", {31'd0, out_valid}, 32'd1);
        check("t2_data",  out_data, 32'h0);
        tick();

        // Fill under backpressure.
        in_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = 32'h100 + 32'(i); in_valid = 1'b1;
            tick();
        end
        in_data = 32'h105;
        check("t3_stall", {31'd0, out_stall}, 32'd1);
        repeat (3) tick();
        check("t3_stall_hold", {31'd0, out_stall}, 32'd1);
        check("t3_valid", {31'd0, out_valid}, 32'd1);
        gap_chk  = 1'b1;
        in_stall = 1'b0;
        g = 0;
        while (out_stall && g < 50) begin tick(); g++; end
        check("t3_unstall", {31'd0, out_stall}, 32'd0);
        tick();
        in_valid = 1'b0;
        drain("t3_drain");
        gap_chk = 1'b0;

        // Backpressure hold while DONE, with a second request queued behind it.
        in_stall = 1'b1;
        send(32'h2000);
        send(32'h3000);
        repeat (3) tick();
        check("t4_valid", {31'd0, out_valid}, 32'd1);
        d0   = out_data;
        ops0 = ops_done;
        check("t4_data", d0, 32'h2001);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("t4_hold_valid", {31'd0, out_valid}, 32'd1);
            check("t4_hold_data",  out_data, d0);
            check("t4_hold_ops",   {16'd0, ops_done}, {16'd0, ops0});
        end
        gap_chk  = 1'b1;
        in_stall = 1'b0;
        drain("t4_drain");
        gap_chk = 1'b0;

        // Flush with a pending result and three queued requests.
        in_stall = 1'b1;
        for (int i = 0; i < 4; i++) send(32'h400 + 32'(i));
        g = 0;
        while (!out_valid && g < 20) begin tick(); g++; end
        check("t5_done", {31'd0, out_valid}, 32'd1);
        ops0     = ops_done;
        in_stall = 1'b0;
        in_flush = 1'b1; in_valid = 1'b1; in_data = 32'h999;
        tick();
        in_flush = 1'b0; in_valid = 1'b0;
        check("t5_valid", {31'd0, out_valid}, 32'd0);
        check("t5_oflush", {31'd0, out_flush}, 32'd1);
        check("t5_stall", {31'd0, out_stall}, 32'd0);
        check("t5_ops", {16'd0, ops_done}, {16'd0, ops0});
        tick();
        check("t5_oflush_low", {31'd0, out_flush}, 32'd0);
        repeat (20) tick();
        check("t5_no_result", {31'd0, out_valid}, 32'd0);
        check("t5_ops_after", {16'd0, ops_done}, {16'd0, ops0});

        // Reset in the middle of BUSY.
        send(32'h50);
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("t6_valid", {31'd0, out_valid}, 32'd0);
        check("t6_data",  out_data, 32'd0);
        check("t6_ops",   {16'd0, ops_done}, 32'd0);
        check("t6_stall", {31'd0, out_stall}, 32'd0);
        repeat (5) tick();
        check("t6_no_stale", {31'd0, out_valid}, 32'd0);
        send(32'h77);
        repeat (3) tick();
        check("t6_not_yet", {31'd0, out_valid}, 32'd0);
        tick();
        check("t6_valid2", {31'd0, out_valid}, 32'd1);
        check("t6_data2",  out_data, 32'h78);
        tick();
        check("t6_ops2", {16'd0, ops_done}, 32'd1);
        check("sb_final", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
